// File: rtl/counter_ctrl.sv
// Push-button front-end for the 4-bit up/down counter: synchronise, debounce and edge-detect three
// buttons into down/step/held mode levels, plus a periodic tick. Define COUNTER_CTRL_AUTOREV_EN for auto-reverse.
module counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       btn_dir,
  input  logic       btn_step,
  input  logic       btn_hold,
  input  logic [3:0] count,
  output logic       down,
  output logic       step,
  output logic       tick,
  output logic       held
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [2:0]       w_btn;
  logic [2:0]       w_press;
  logic             w_down_nxt;
  logic             w_step_nxt;
  logic             w_held_nxt;

  logic             r_down;
  logic             r_step;
  logic             r_tick;
  logic             r_held;
  logic [DIV_W-1:0] r_div;

  assign w_btn = {btn_hold, btn_step, btn_dir};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: non-blocking assignments let every register sample the pre-edge values, so the two
    // synchroniser stages really are two stages and not one wire.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_btn[g];
        r_s2 <= r_s1;
      end
    end

    // NOTE: the debounce counter is reset along with the level, otherwise a press pending at reset
    // would complete early afterwards.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_db  <= 1'b0;
        r_cnt <= '0;
      end else if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    // Press fires on the same edge the debounced level rises.
    assign w_press[g] = r_s2 && !r_db && (r_cnt == CNT_LAST);
  end

  assign w_step_nxt = r_step ^ w_press[1];
  assign w_held_nxt = r_held ^ w_press[2];

`ifdef COUNTER_CTRL_AUTOREV_EN
  logic w_up_lim;
  logic w_dn_lim;

  // NOTE: every path assigns w_down_nxt, so no latch is inferred.
  always_comb begin
    w_up_lim = !r_down && (r_step ? (count >= 4'd14) : (count == 4'd15));
    w_dn_lim = r_down && (r_step ? (count <= 4'd1) : (count == 4'd0));
    if (w_up_lim)      w_down_nxt = 1'b1;
    else if (w_dn_lim) w_down_nxt = 1'b0;
    else               w_down_nxt = r_down ^ w_press[0];
  end
`else
  logic w_count_unused;
  assign w_count_unused = ^count;
  assign w_down_nxt     = r_down ^ w_press[0];
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_down <= 1'b0;
      r_step <= 1'b0;
      r_held <= 1'b0;
    end else begin
      r_down <= w_down_nxt;
      r_step <= w_step_nxt;
      r_held <= w_held_nxt;
    end
  end

  // Freeze on the upcoming held level so a hold landing on a wrap edge swallows that tick.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (w_held_nxt) begin
      r_tick <= 1'b0;
    end else if (r_div == DIV_LAST) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign down = r_down;
  assign step = r_step;
  assign tick = r_tick;
  assign held = r_held;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: a cycle model feeds an expected-output queue that is
// compared every cycle, plus directed latency/boundary checks.
module tb_counter_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic       clk      = 1'b0;
  logic       nrst     = 1'b1;
  logic       btn_dir  = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_hold = 1'b0;
  logic [3:0] count    = 4'd8;
  logic       down, step, tick, held;

  counter_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(DIV)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .btn_dir  (btn_dir),
    .btn_step (btn_step),
    .btn_hold (btn_hold),
    .count    (count),
    .down     (down),
    .step     (step),
    .tick     (tick),
    .held     (held)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         edge_n   = 0;
  int         unheld   = 0;
  logic [3:0] exp_q[$];

  logic [2:0] m_s1, m_s2, m_db;
  int         m_cnt[3];
  logic       m_down, m_step, m_tick, m_held;
  int         m_div;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_down = 1'b0; m_step = 1'b0; m_tick = 1'b0; m_held = 1'b0;
    m_div  = 0;
  endtask

  task automatic model_step();
    logic [2:0] btn;
    logic [2:0] press;
    logic       held_n;
    btn = {btn_hold, btn_step, btn_dir};
    for (int i = 0; i < 3; i++) begin
      press[i] = m_s2[i] && !m_db[i] && (m_cnt[i] == DEB - 1);
      if (m_s2[i] == m_db[i]) m_cnt[i] = 0;
      else if (m_cnt[i] == DEB - 1) begin
        m_db[i]  = m_s2[i];
        m_cnt[i] = 0;
      end else m_cnt[i]++;
    end
    m_s2   = m_s1;
    m_s1   = btn;
    held_n = m_held ^ press[2];
`ifdef COUNTER_CTRL_AUTOREV_EN
    if (!m_down && (m_step ? (count >= 4'd14) : (count == 4'd15)))    m_down = 1'b1;
    else if (m_down && (m_step ? (count <= 4'd1) : (count == 4'd0))) m_down = 1'b0;
    else                                                             m_down = m_down ^ press[0];
`else
    m_down = m_down ^ press[0];
`endif
    m_step = m_step ^ press[1];
    if (held_n) m_tick = 1'b0;
    else if (m_div == DIV - 1) begin
      m_div  = 0;
      m_tick = 1'b1;
    end else begin
      m_div  = m_div + 1;
      m_tick = 1'b0;
    end
    m_held = held_n;
  endtask

  // Model advances on the same edge as the DUT; the DUT result is compared half a cycle later.
  task automatic run_cycle();
    @(posedge clk);
    edge_n++;
    model_step();
    exp_q.push_back({m_down, m_step, m_tick, m_held});
    @(negedge clk);
    check("scoreboard", {down, step, tick, held}, exp_q.pop_front());
    if (!held) unheld++;
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    #2;
    model_reset();
    exp_q.delete();
    check("reset_outputs", {down, step, tick, held}, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    nrst   = 1'b1;
    edge_n = 0;
  endtask

  task automatic wait_down(input logic val, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      run_cycle();
      if (down === val) begin
        at = edge_n;
        break;
      end
    end
  endtask

  task automatic wait_tick(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      run_cycle();
      if (tick === 1'b1) begin
        at = edge_n;
        break;
      end
    end
  endtask

  initial begin
    int   at;
    int   t0;
    logic pd, ps;
    #1;
    apply_reset();

    // Idle: ticks only at edges 8 and 16.
    for (int i = 0; i < 20; i++) begin
      run_cycle();
      check("idle_tick", tick, (edge_n == 8 || edge_n == 16));
    end
    check("idle_modes", {down, step, held}, 3'b000);

    // Direction press first sampled at edge 10 lands at edge 15.
    apply_reset();
    repeat (9) run_cycle();
    btn_dir = 1'b1;
    wait_down(1'b1, 30, at);
    check("dir_latency", at, 15);
    btn_dir = 1'b0;
    repeat (8) run_cycle();
    check("dir_release", down, 1'b1);
    btn_dir = 1'b1;
    repeat (8) run_cycle();
    check("dir_second", down, 1'b0);
    btn_dir = 1'b0;
    repeat (8) run_cycle();

    // Short glitch ignored, long press accepted.
    btn_step = 1'b1;
    repeat (3) run_cycle();
    btn_step = 1'b0;
    repeat (10) run_cycle();
    check("step_glitch", step, 1'b0);
    btn_step = 1'b1;
    repeat (6) run_cycle();
    btn_step = 1'b0;
    repeat (10) run_cycle();
    check("step_press", step, 1'b1);

    // Hold: no ticks while paused, tick interval counts only unheld edges.
    wait_tick(20, at);
    check("tick_found", (at > 0), 1'b1);
    unheld   = 0;
    btn_hold = 1'b1;
    repeat (6) run_cycle();
    btn_hold = 1'b0;
    check("held_set", held, 1'b1);
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      check("held_no_tick", {held, tick}, 2'b10);
    end
    btn_hold = 1'b1;
    repeat (6) run_cycle();
    btn_hold = 1'b0;
    check("held_clear", held, 1'b0);
    wait_tick(20, at);
    check("held_interval", unheld, DIV);

    // Hold event on the very edge a tick would fire suppresses it.
    t0 = at;
    repeat (2) run_cycle();
    btn_hold = 1'b1;
    repeat (5) run_cycle();
    run_cycle();
    check("sup_edge", edge_n, t0 + DIV);
    check("sup_tick", {held, tick}, 2'b10);
    btn_hold = 1'b0;
    repeat (8) run_cycle();
    btn_hold = 1'b1;
    repeat (6) run_cycle();
    btn_hold = 1'b0;
    check("unhold", held, 1'b0);
    repeat (10) run_cycle();

    // Simultaneous events on two buttons both apply.
    pd       = down;
    ps       = step;
    btn_dir  = 1'b1;
    btn_step = 1'b1;
    repeat (5) run_cycle();
    check("simul_wait", {down, step}, {pd, ps});
    run_cycle();
    check("simul_apply", {down, step}, {~pd, ~ps});
    btn_dir  = 1'b0;
    btn_step = 1'b0;
    repeat (8) run_cycle();

    // Reset mid-debounce drops the pending press; still-held button re-qualifies from scratch.
    btn_dir = 1'b1;
    repeat (2) run_cycle();
    apply_reset();
    wait_down(1'b1, 20, at);
    check("rst_latency", at, 2 + DEB);
    btn_dir = 1'b0;
    repeat (8) run_cycle();

    apply_reset();
`ifdef COUNTER_CTRL_AUTOREV_EN
    count = 4'd15;
    run_cycle();
    check("ar_up_limit", down, 1'b1);
    count    = 4'd8;
    btn_step = 1'b1;
    repeat (6) run_cycle();
    btn_step = 1'b0;
    check("ar_step_set", {down, step}, 2'b11);
    count = 4'd1;
    run_cycle();
    check("ar_dn_limit_step2", down, 1'b0);
    count   = 4'd8;
    btn_dir = 1'b1;
    repeat (5) run_cycle();
    check("ar_pre_event", down, 1'b0);
    count = 4'd15;
    run_cycle();
    check("ar_event_override", down, 1'b1);
    btn_dir = 1'b0;
    count   = 4'd8;
    repeat (8) run_cycle();
`else
    count = 4'd15;
    repeat (3) run_cycle();
    check("count_ignored", down, 1'b0);
    count = 4'd0;
    repeat (3) run_cycle();
    check("count_ignored_zero", down, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
